// File: rtl/i2c_byte_master.sv
// Single-byte I2C master bit engine: START, 7-bit address + R/W, ACK check,
// one data byte (write, or read finished with a master NACK), STOP.
// SCL comes from a free-running clk-synchronous source and is gated onto the bus.
module i2c_byte_master #(
  parameter int unsigned SDA_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_o,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  typedef enum logic [3:0] {
    IDLE, WAIT_START, START_HOLD, ADDR, ADDR_ACK, WDATA, WDATA_ACK,
    RDATA, RNACK, STOP1, STOP2, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_prev_q;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sda_oe_q, sda_oe_d;
  logic        scl_gate_q, scl_gate_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sda_s;
  logic        rise, fall;

  // SDA pad synchronizer, SDA_SYNC flops deep (bus idles high)
  generate
    if (SDA_SYNC == 0) begin : g_nosync
      assign sda_s = sda_in;
    end else begin : g_sync
      logic [SDA_SYNC-1:0] sync_q;
      // shift sda_in through the synchronizer chain
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= sda_in;
          for (int unsigned i = 1; i < SDA_SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign sda_s = sync_q[SDA_SYNC-1];
    end
  endgenerate

  assign rise = scl & ~scl_prev_q;
  assign fall = ~scl & scl_prev_q;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      scl_prev_q <= 1'b0;
      sh_q       <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      sda_oe_q   <= 1'b0;
      scl_gate_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      scl_prev_q <= scl;
      sh_q       <= sh_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      cnt_q      <= cnt_d;
      sda_oe_q   <= sda_oe_d;
      scl_gate_q <= scl_gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // next-state and bus-drive decisions, acting on detected scl edges
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    cnt_d      = cnt_q;
    sda_oe_d   = sda_oe_q;
    scl_gate_d = scl_gate_q;
    ack_err_d  = ack_err_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE, DONE: begin
        sda_oe_d   = 1'b0;
        scl_gate_d = 1'b0;
        state_d    = IDLE;
        if (start) begin
          sh_d      = {addr, rw};
          wdata_d   = wdata;
          rw_d      = rw;
          ack_err_d = 1'b0;
          state_d   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (rise) begin
          sda_oe_d = 1'b1;
          state_d  = START_HOLD;
        end
      end
      START_HOLD: begin
        if (fall) begin
          scl_gate_d = 1'b1;
          sda_oe_d   = ~sh_q[7];
          cnt_d      = 3'd7;
          state_d    = ADDR;
        end
      end
      ADDR, WDATA: begin
        if (fall) begin
          if (cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = (state_q == ADDR) ? ADDR_ACK : WDATA_ACK;
          end else begin
            sh_d     = {sh_q[6:0], 1'b0};
            cnt_d    = cnt_q - 3'd1;
            sda_oe_d = ~sh_q[6];
          end
        end
      end
      ADDR_ACK: begin
        if (rise) begin
          ack_err_d = sda_s;
        end else if (fall) begin
          if (ack_err_q) begin
            sda_oe_d = 1'b1;
            state_d  = STOP1;
          end else if (!rw_q) begin
            sh_d     = wdata_q;
            sda_oe_d = ~wdata_q[7];
            cnt_d    = 3'd7;
            state_d  = WDATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd7;
            state_d  = RDATA;
          end
        end
      end
      WDATA_ACK: begin
        if (rise) begin
          ack_err_d = sda_s;
        end else if (fall) begin
          sda_oe_d = 1'b1;
          state_d  = STOP1;
        end
      end
      RDATA: begin
        // counter steps on falls so the 8th rise is followed by the exit fall
        if (rise) begin
          rdata_d = {rdata_q[6:0], sda_s};
        end else if (fall) begin
          if (cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = RNACK;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      RNACK: begin
        if (fall) begin
          sda_oe_d = 1'b1;
          state_d  = STOP1;
        end
      end
      STOP1: begin
        if (rise) begin
          scl_gate_d = 1'b0;
          state_d    = STOP2;
        end
      end
      STOP2: begin
        if (fall) begin
          sda_oe_d = 1'b0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  assign scl_o   = scl_gate_q ? scl : 1'b1;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule
